pll_lock_sequencer: RTL and testbench

Sequences bring-up of the ECP5 EHXPLLL that generates the 16 MHz display clock from the 25 MHz board oscillator. Runs on the raw oscillator, so it works while the PLL is unlocked. It supervises the PLL `locked` output: it drives `pll_rst` pulses, debounces lock, enforces a lock timeout with bounded retries, and releases the display-domain reset only after lock has been continuously stable. It consumes the PLL's `locked` output and drives the PLL's `RST` input.

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/pll_lock_sequencer_sync_ff.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } pll_state_e;

  // Defaults assume the 25 MHz board oscillator.
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 25000;
  localparam int unsigned DEF_STABLE_CYCLES       = 2500;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned cyc_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
module sync_ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-stage capture; both stages clear to 0 on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Bring-up supervisor for the display-clock PLL, clocked by the raw oscillator.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN adds the lock_loss_count output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// PRST   | pll_rst asserted for RST_PULSE_CYCLES
// WAIT   | waiting for locked_s, bounded by LOCK_TIMEOUT_CYCLES
// STABLE | counting consecutive locked_s samples before release
// RUN    | display-domain reset released, ready asserted
// FAIL   | retries exhausted; only reset_n leaves this state
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       system_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int unsigned MAX_CYC = cyc_max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             pll_rst_q, sys_rst_n_q, ready_q, fail_q;
  logic             locked_s;

  sync_ff u_lock_sync (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  // Next-state, retry bookkeeping and the shared cycle counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_PRST: begin
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Lock takes priority over a timeout expiring on the same cycle.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_PRST;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s)                 state_d = ST_WAIT;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          retry_d = 2'd0;
          state_d = ST_PRST;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PRST;
    endcase

    // Clears on any state change and saturates so long stays in RUN never wrap.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_W'(1);
  end

  // State, counter and outputs decoded from next-state so they move together.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PRST;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == ST_PRST);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst        = pll_rst_q;
  assign system_reset_n = sys_rst_n_q;
  assign ready          = ready_q;
  assign fail           = fail_q;
  assign retry_count    = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;
  logic       loss_evt;

  assign loss_evt = (state_q == ST_RUN) && (state_d == ST_PRST);

  // Saturating count of lock losses while running; cleared only by reset_n.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)                          loss_cnt_q <= 8'd0;
    else if (loss_evt && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
  end

  assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       pll_rst;
  logic       system_reset_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int errors = 0;
  int checks = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clock_in       (clk),
    .reset_n        (reset_n),
    .locked         (locked),
    .pll_rst        (pll_rst),
    .system_reset_n (system_reset_n),
    .ready          (ready),
    .fail           (fail),
    .retry_count    (retry_count)
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two cycles, release on a falling edge (sample index 0).
  task automatic apply_reset();
    reset_n = 1'b0;
    locked  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    locked  = 1'b0;
    step(1);
    #2;
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (system_reset_n !== 1'b0) begin errors++; $display("FAIL reset_srn got=%b exp=0", system_reset_n); end
    checks++; if (ready !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_ready_fail got=%b%b exp=00", ready, fail); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
  endtask

  task automatic test_normal();
    int hi;
    int first;
    apply_reset();
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      if (pll_rst === 1'b1) hi++;
    end
    checks++; if (hi !== 4) begin errors++; $display("FAIL normal_pulse_width got=%0d exp=4", hi); end
    step(1);
    locked = 1'b1;
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      step(1);
      if (system_reset_n === 1'b1 && first == 0) first = n;
    end
    checks++; if (first !== 11) begin errors++; $display("FAIL normal_release_latency got=%0d exp=11", first); end
    checks++; if (ready !== 1'b1 || pll_rst !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL normal_run_outputs got=%b%b%b exp=100", ready, pll_rst, fail); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL normal_retry got=%0d exp=0", retry_count); end
  endtask

  task automatic test_timeout();
    int bad_pr, bad_fl, bad_rc, pulses, bad_hold;
    logic prev, exp_pr, exp_fl;
    logic [1:0] exp_rc;
    apply_reset();
    bad_pr = 0; bad_fl = 0; bad_rc = 0; pulses = 0; bad_hold = 0;
    prev = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) step(1);
      exp_pr = (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52);
      exp_fl = (k >= 72);
      exp_rc = (k < 24) ? 2'd0 : (k < 48) ? 2'd1 : 2'd2;
      if (pll_rst !== exp_pr) bad_pr++;
      if (fail !== exp_fl) bad_fl++;
      if (retry_count !== exp_rc) bad_rc++;
      if (pll_rst === 1'b1 && prev == 1'b0) pulses++;
      prev = pll_rst;
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL timeout_pulse_count got=%0d exp=3", pulses); end
    checks++; if (bad_pr !== 0) begin errors++; $display("FAIL timeout_pll_rst_pattern bad_samples=%0d exp=0", bad_pr); end
    checks++; if (bad_fl !== 0) begin errors++; $display("FAIL timeout_fail_timing bad_samples=%0d exp=0", bad_fl); end
    checks++; if (bad_rc !== 0) begin errors++; $display("FAIL timeout_retry_seq bad_samples=%0d exp=0", bad_rc); end
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (fail !== 1'b1 || pll_rst !== 1'b0 || system_reset_n !== 1'b0 || ready !== 1'b0) bad_hold++;
    end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL timeout_terminal_hold bad_samples=%0d exp=0", bad_hold); end
  endtask

  task automatic test_unstable();
    int first;
    apply_reset();
    step(10);
    locked = 1'b1;
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    first = 0;
    for (int k = 17; k <= 45; k++) begin
      step(1);
      if (system_reset_n === 1'b1 && first == 0) first = k;
    end
    checks++; if (first !== 27) begin errors++; $display("FAIL unstable_release_index got=%0d exp=27", first); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL unstable_retry got=%0d exp=0", retry_count); end
  endtask

  task automatic test_loss();
    int first;
    int waited;
    apply_reset();
    step(30);
    locked = 1'b1;
    waited = 0;
    while (ready !== 1'b1 && waited < 40) begin step(1); waited++; end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_reach_run got=%b exp=1", ready); end
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL loss_retry_in_run got=%0d exp=1", retry_count); end
    step(2);
    locked = 1'b0;
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      step(1);
      if (system_reset_n === 1'b0 && first == 0) begin
        first = n;
        checks++; if (pll_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL loss_outputs got=%b%b exp=10", pll_rst, ready); end
        checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL loss_retry_clear got=%0d exp=0", retry_count); end
      end
    end
    checks++; if (first !== 3) begin errors++; $display("FAIL loss_latency got=%0d exp=3", first); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (lock_loss_count !== 8'd1) begin errors++; $display("FAIL loss_count got=%0d exp=1", lock_loss_count); end
`endif
  endtask

  task automatic test_async_reset();
    int hi;
    // mid-STABLE
    apply_reset();
    step(10);
    locked = 1'b1;
    step(6);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || system_reset_n !== 1'b0 || ready !== 1'b0 || fail !== 1'b0 || retry_count !== 2'd0) begin
      errors++; $display("FAIL async_stable got=%b%b%b%b%0d exp=1000_0", pll_rst, system_reset_n, ready, fail, retry_count);
    end
    locked = 1'b0;
    step(1);
    reset_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      if (pll_rst === 1'b1) hi++;
    end
    checks++; if (hi !== 4) begin errors++; $display("FAIL async_stable_restart got=%0d exp=4", hi); end
    // in RUN
    apply_reset();
    step(10);
    locked = 1'b1;
    step(15);
    checks++; if (system_reset_n !== 1'b1) begin errors++; $display("FAIL async_run_pre got=%b exp=1", system_reset_n); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (system_reset_n !== 1'b0 || ready !== 1'b0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL async_run got=%b%b%b exp=001", system_reset_n, ready, pll_rst);
    end
    // in terminal state
    apply_reset();
    step(75);
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL async_term_pre got=%b exp=1", fail); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fail !== 1'b0 || pll_rst !== 1'b1 || retry_count !== 2'd0) begin
      errors++; $display("FAIL async_term got=%b%b%0d exp=01_0", fail, pll_rst, retry_count);
    end
    step(1);
    reset_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      if (pll_rst === 1'b1) hi++;
    end
    checks++; if (hi !== 4) begin errors++; $display("FAIL async_term_restart got=%0d exp=4", hi); end
  endtask

`ifdef PLL_SEQ_LOSS_COUNT_EN
  task automatic test_saturation();
    int waited;
    int stuck;
    apply_reset();
    locked = 1'b1;
    stuck = 0;
    for (int i = 0; i < 258; i++) begin
      waited = 0;
      while (ready !== 1'b1 && waited < 40) begin step(1); waited++; end
      if (ready !== 1'b1) begin stuck = 1; break; end
      locked = 1'b0;
      step(3);
      locked = 1'b1;
    end
    checks++; if (stuck !== 0) begin errors++; $display("FAIL sat_relock got=%0d exp=0", stuck); end
    checks++; if (lock_loss_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", lock_loss_count); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    locked  = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_unstable();
    test_loss();
    test_async_reset();
`ifdef PLL_SEQ_LOSS_COUNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
